dmem_resp: RTL and testbench
============================

Name: dmem_resp

Overview:
Data-memory responder for the core's load/store port. It accepts one load or store request at a time over a valid/ready handshake and performs RISC-V byte, halfword and word accesses against an internal word array. It returns a response (read data plus error flag) after a configurable latency. Sits between the core's MEM stage and on-chip data storage; it is the serving end of the addresses and data the core generates from rs1+imm.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >=4)
LATENCY, 1, cycles from request accept edge to rsp_valid high (>=1)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0 (word aligned)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V load/store funct3 (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2)
req_addr  in  32  byte address
req_wdata  in  32  store data, low-aligned (SB uses [7:0], SH uses [15:0])
rsp_valid  out  1  response present
rsp_ready  in  1  requester takes response
rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors
rsp_err  out  1  misaligned, out-of-range, or illegal funct3

Behaviour:
- Reset (rst high at edge): state IDLE, rsp_valid 0, rsp_err 0, rsp_rdata 0, latency counter 0. req_ready is 1 in the first cycle after reset. Array contents are not reset.
- Reset mid-operation: any pending request is discarded. A store that has not yet reached its commit edge is never written.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid & req_ready, latch we, funct3, addr and wdata; no input is sampled after this point.
  - If LATENCY=1, go to RESP.
  - Otherwise load counter with LATENCY-1 and go to WAIT.
- WAIT: counter decrements by 1 per cycle; when it reaches 1, go to RESP.
- Commit edge: the edge entering RESP. The array access, the store write, and the rsp_rdata/rsp_err registration all happen on this edge. rsp_valid rises exactly LATENCY cycles after the accept edge.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err hold stable until the handshake. On rsp_ready, go to IDLE. The next request can be accepted no earlier than the cycle after the handshake (no same-cycle turnaround).
- Offset = addr - BASE_ADDR; word index = offset[31:2]; lane = offset[1:0].
- Error if any of:
  - word index >= DEPTH_WORDS, or offset negative (addr < BASE_ADDR);
  - half access with lane[0]=1;
  - word access with lane!=0;
  - load funct3 in {3,6,7};
  - store funct3 > 2.
- On error: no write, rsp_rdata=0, rsp_err=1.
- Stores write byte lanes only:
  - SB writes lane with wdata[7:0];
  - SH writes bytes lane and lane+1 (lane 0 or 2) with wdata[15:0];
  - SW writes all four bytes.
  - Unwritten bytes are unchanged. Response is rdata 0, err 0.
- Loads:
  - LB/LBU: select byte at lane, then sign- or zero-extend to 32.
  - LH/LHU: select half at lane[1], then sign- or zero-extend to 32.
  - LW: return the full word.
- Response ordering: exactly one response per accepted request, in order. Never more than one request outstanding.

Test Plan:
1. SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=1 and LATENCY=3 builds) -> rdata 0xDEADBEEF, err 0; rsp_valid exactly LATENCY cycles after each accept.
2. After test 1, SB wdata 0x00000080 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
3. SH wdata 0x0000F234 @0x12, then LH @0x12 -> 0xFFFFF234; LHU @0x12 -> 0x0000F234; LW @0x10 -> 0xF234BEEF.
4. Error cases, each -> err 1 and rdata 0:
   - LW @0x11;
   - SH @0x13 (follow with LW @0x10: unchanged);
   - LW @(4*DEPTH_WORDS);
   - load with funct3=3.
5. Hold rsp_ready low for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready 0, a held req_valid not accepted. Raise rsp_ready -> IDLE; the held request is accepted the following cycle.
6. LATENCY=4: SW 0x11111111 @0x20 (prior value 0xA5A5A5A5), assert rst 2 cycles after accept -> rsp_valid 0 and req_ready 1 after reset; then LW @0x20 -> 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_resp_if.sv
// Load/store port between the core's MEM stage and the data-memory responder.
// The master issues requests and takes responses; the slave serves them.
interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding RISC-V byte/half/word load or store,
// answered LATENCY cycles after acceptance from a byte-lane word array.
module dmem_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  dmem_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;

  logic          accept;
  logic          commit;
  logic          wr_en;
  logic          acc_we;
  logic [2:0]    acc_f3;
  logic [31:0]   acc_addr, acc_wdata, acc_off;
  logic [1:0]    acc_lane;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wlane;
  logic [31:0]   raw_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign accept = (state_q == IDLE) && bus.req_valid;
  assign commit = (state_d == RESP) && (state_q != RESP);
  assign wr_en  = commit && acc_we && !acc_err && !rst;

  // With LATENCY=1 the commit edge is the accept edge, so the access must use
  // the live request rather than the not-yet-loaded latches.
  always_comb begin
    acc_we    = (state_q == IDLE) ? bus.req_we     : we_q;
    acc_f3    = (state_q == IDLE) ? bus.req_funct3 : funct3_q;
    acc_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
    acc_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
    acc_off   = acc_addr - BASE_ADDR;
    acc_lane  = acc_off[1:0];
    acc_idx   = acc_off[AW+1:2];
    acc_err   = (acc_addr < BASE_ADDR) || (acc_off[31:AW+2] != '0);
    if (acc_we) acc_err = acc_err || (acc_f3 > 3'd2);
    else        acc_err = acc_err || (acc_f3 == 3'd3) || (acc_f3 == 3'd6) || (acc_f3 == 3'd7);
    if (acc_f3[1:0] == 2'd1 && acc_lane[0])     acc_err = 1'b1;
    if (acc_f3[1:0] == 2'd2 && acc_lane != 2'd0) acc_err = 1'b1;
    case (acc_f3[1:0])
      2'd0: begin
        acc_be    = 4'b0001 << acc_lane;
        acc_wlane = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        acc_be    = acc_lane[1] ? 4'b1100 : 4'b0011;
        acc_wlane = {2{acc_wdata[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wlane = acc_wdata;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (wr_en && acc_be[gi]) mem[acc_idx] <= acc_wlane[gi*8 +: 8];
      if (commit) rd_q <= mem[acc_idx];
    end
    assign raw_word[gi*8 +: 8] = rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (accept) begin
      we_d     = bus.req_we;
      funct3_d = bus.req_funct3;
      addr_d   = bus.req_addr;
      wdata_d  = bus.req_wdata;
      cnt_d    = CW'(LATENCY - 1);
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (commit) err_d = acc_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // BASE_ADDR is word aligned, so the latched address carries the lane directly.
  assign ld_byte = raw_word[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = raw_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_err   = (state_q == RESP) && err_q;
    bus.rsp_rdata = '0;
    if (state_q == RESP && !err_q && !we_q) begin
      case (funct3_q)
        3'd0:    bus.rsp_rdata = {{24{ld_byte[7]}}, ld_byte};
        3'd1:    bus.rsp_rdata = {{16{ld_half[15]}}, ld_half};
        3'd4:    bus.rsp_rdata = {24'h0, ld_byte};
        3'd5:    bus.rsp_rdata = {16'h0, ld_half};
        default: bus.rsp_rdata = raw_word;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_resp.sv
// Drives three responders (LATENCY 1, 3, 4) from one request table plus
// hand-written back-pressure and reset-abort sequences; results via scoreboard.
module tb_dmem_resp;
  localparam int DEPTH = 64;

  typedef struct {
    int          sel;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  int          sel;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic [2:0]       req_ready_w, rsp_valid_w, rsp_err_w;
  logic [2:0][31:0] rsp_rdata_w;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass;
  int   n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
    dmem_resp_if bus ();
    assign bus.req_valid   = req_valid && (sel == gi);
    assign bus.req_we      = req_we;
    assign bus.req_funct3  = req_funct3;
    assign bus.req_addr    = req_addr;
    assign bus.req_wdata   = req_wdata;
    assign bus.rsp_ready   = rsp_ready && (sel == gi);
    assign req_ready_w[gi] = bus.req_ready;
    assign rsp_valid_w[gi] = bus.rsp_valid;
    assign rsp_err_w[gi]   = bus.rsp_err;
    assign rsp_rdata_w[gi] = bus.rsp_rdata;
    dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(32'h0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input int s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.sel = s; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic send(input int s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    bit   ok = 0;
    sel = s; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    for (int k = 0; k < 20; k++) begin
      if (req_ready_w[s]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check($sformatf("accept_timeout dut%0d", s), 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic receive(input int s);
    int   n = 1;
    exp_t e;
    while (!rsp_valid_w[s] && n < 30) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("latency dut%0d", s), 32'(n), 32'(lat_of(s)));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("rdata dut%0d", s), rsp_rdata_w[s], e.rdata);
      check($sformatf("err dut%0d", s), 32'(rsp_err_w[s]), 32'(e.err));
    end
    $display("txn dut%0d we=%0b f3=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             s, req_we, req_funct3, req_addr, req_wdata, rsp_rdata_w[s], rsp_err_w[s], n);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("idle_ready dut%0d", s), 32'(req_ready_w[s]), 32'd1);
    check($sformatf("valid_drop dut%0d", s), 32'(rsp_valid_w[s]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0;
    sel = 0; rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;

    // Tests 1-4 on the LATENCY=1 and LATENCY=3 builds, extra lane cases on LATENCY=4.
    add(0, 1, 2, 32'h10, 32'hDEADBEEF, 32'h0,        0);
    add(0, 0, 2, 32'h10, 32'h0,        32'hDEADBEEF, 0);
    add(1, 1, 2, 32'h10, 32'hDEADBEEF, 32'h0,        0);
    add(1, 0, 2, 32'h10, 32'h0,        32'hDEADBEEF, 0);
    add(1, 1, 0, 32'h13, 32'h00000080, 32'h0,        0);
    add(1, 0, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0);
    add(1, 0, 4, 32'h13, 32'h0,        32'h00000080, 0);
    add(1, 0, 2, 32'h10, 32'h0,        32'h80ADBEEF, 0);
    add(1, 1, 1, 32'h12, 32'h0000F234, 32'h0,        0);
    add(1, 0, 1, 32'h12, 32'h0,        32'hFFFFF234, 0);
    add(1, 0, 5, 32'h12, 32'h0,        32'h0000F234, 0);
    add(1, 0, 2, 32'h10, 32'h0,        32'hF234BEEF, 0);
    add(1, 0, 2, 32'h11, 32'h0,        32'h0,        1);
    add(1, 1, 1, 32'h13, 32'h0000ABCD, 32'h0,        1);
    add(1, 0, 2, 32'h10, 32'h0,        32'hF234BEEF, 0);
    add(1, 0, 2, 32'(4*DEPTH), 32'h0,  32'h0,        1);
    add(1, 0, 3, 32'h10, 32'h0,        32'h0,        1);
    add(1, 0, 7, 32'h10, 32'h0,        32'h0,        1);
    add(1, 1, 3, 32'h10, 32'h12345678, 32'h0,        1);
    add(1, 0, 2, 32'h10, 32'h0,        32'hF234BEEF, 0);
    add(2, 1, 2, 32'h04, 32'h01234567, 32'h0,        0);
    add(2, 0, 1, 32'h06, 32'h0,        32'h00000123, 0);
    add(2, 0, 0, 32'h05, 32'h0,        32'h00000045, 0);
    add(2, 0, 4, 32'h04, 32'h0,        32'h00000067, 0);
    add(2, 1, 0, 32'h04, 32'h123456FF, 32'h0,        0);
    add(2, 0, 2, 32'h04, 32'h0,        32'h012345FF, 0);
    add(2, 1, 1, 32'h06, 32'h00000000, 32'h0,        0);
    add(2, 0, 2, 32'h04, 32'h0,        32'h000045FF, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ready dut%0d", d), 32'(req_ready_w[d]), 32'd1);
      check($sformatf("reset_valid dut%0d", d), 32'(rsp_valid_w[d]), 32'd0);
      check($sformatf("reset_err dut%0d", d), 32'(rsp_err_w[d]), 32'd0);
      check($sformatf("reset_rdata dut%0d", d), rsp_rdata_w[d], 32'd0);
    end

    foreach (vecs[i]) begin
      send(vecs[i].sel, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rdata, vecs[i].exp_err);
      receive(vecs[i].sel);
    end

    // Back-pressure: response held for 5 cycles while a new request waits.
    begin
      int   n = 1;
      exp_t e;
      send(1, 0, 2, 32'h10, 32'h0, 32'hF234BEEF, 0);
      while (!rsp_valid_w[1] && n < 30) begin
        @(negedge clk);
        n++;
      end
      check("bp_latency", 32'(n), 32'd3);
      e = sb.pop_front();
      req_we = 1'b0; req_funct3 = 3'd5; req_addr = 32'h12; req_wdata = 32'h0;
      req_valid = 1'b1;
      sb.push_back('{rdata: 32'h0000F234, err: 1'b0});
      for (int k = 0; k < 5; k++) begin
        check($sformatf("bp_valid c%0d", k), 32'(rsp_valid_w[1]), 32'd1);
        check($sformatf("bp_rdata c%0d", k), rsp_rdata_w[1], e.rdata);
        check($sformatf("bp_err c%0d", k), 32'(rsp_err_w[1]), 32'(e.err));
        check($sformatf("bp_ready c%0d", k), 32'(req_ready_w[1]), 32'd0);
        @(negedge clk);
      end
      $display("txn dut1 held response rdata=%h err=%0b", rsp_rdata_w[1], rsp_err_w[1]);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp_idle_ready", 32'(req_ready_w[1]), 32'd1);
      check("bp_idle_valid", 32'(rsp_valid_w[1]), 32'd0);
      @(negedge clk);
      check("bp_held_accepted", 32'(req_ready_w[1]), 32'd0);
      req_valid = 1'b0;
      receive(1);
    end

    // Reset two cycles after accepting a LATENCY=4 store: it must never commit.
    send(2, 1, 2, 32'h20, 32'hA5A5A5A5, 32'h0, 0);
    receive(2);
    sel = 2; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h11111111;
    req_valid = 1'b1;
    check("abort_ready_before", 32'(req_ready_w[2]), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid_after_rst", 32'(rsp_valid_w[2]), 32'd0);
    check("abort_ready_after_rst", 32'(req_ready_w[2]), 32'd1);
    repeat (4) @(negedge clk);
    check("abort_no_phantom_rsp", 32'(rsp_valid_w[2]), 32'd0);
    $display("txn dut2 aborted store addr=00000020 wdata=11111111");
    send(2, 0, 2, 32'h20, 32'h0, 32'hA5A5A5A5, 0);
    receive(2);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
